game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer for a breakout-style game: serve/play/lost/over/win,
// lives, banked score and speed-level control.
// Ports:
//   i_clk, i_rst_n (async active-low), i_ani_stb (frame strobe),
//   i_start (level), i_endgame, i_win, i_score[13:0] from the ball block;
//   o_mode, o_animate, o_speed[3:0], o_lives[1:0], o_total[13:0], o_state[2:0].
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int SPEEDUP_STEP = 50,
  parameter int MAX_SPEED    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ani_stb,
  input  logic        i_start,
  input  logic        i_endgame,
  input  logic        i_win,
  input  logic [13:0] i_score,
  output logic        o_mode,
  output logic        o_animate,
  output logic [3:0]  o_speed,
  output logic [1:0]  o_lives,
  output logic [13:0] o_total,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_LOST  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  localparam logic [1:0]  LIVES_V = 2'(LIVES);
  localparam logic [15:0] STEP_V  = 16'(SPEEDUP_STEP);
  localparam logic [3:0]  MAXS_V  = 4'(MAX_SPEED);
  localparam logic [7:0]  SLAST_V = 8'(SERVE_FRAMES - 1);

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic        anim_q, anim_d;
  logic [3:0]  speed_q, speed_d;
  logic [1:0]  lives_q, lives_d;
  logic [13:0] total_q, total_d;
  logic [13:0] banked_q, banked_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] thr_q, thr_d;
  logic        start_q;

  logic        start_edge;
  logic [14:0] bank_sum;
  logic [14:0] tot_sum;

  // Previous sample resets high so a button held through reset is ignored.
  assign start_edge = i_start & ~start_q;

  assign bank_sum = {1'b0, banked_q} + {1'b0, i_score};
  assign tot_sum  = {1'b0, banked_q}
                  + {1'b0, (mode_q ? i_score : 14'd0)};

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    lives_d  = lives_q;
    banked_d = banked_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d  = S_SERVE;
          lives_d  = LIVES_V;
          banked_d = 14'd0;
          speed_d  = 4'd1;
          thr_d    = STEP_V;
          cnt_d    = 8'd0;
        end
      end
      S_SERVE: begin
        if (i_ani_stb) begin
          if (cnt_q == SLAST_V) begin
            state_d = S_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (i_win) begin
          state_d = S_WIN;
        end else if (i_endgame) begin
          state_d = S_LOST;
        end
        if (i_ani_stb && ({2'b00, total_q} >= thr_q)
            && (speed_q < MAXS_V)) begin
          speed_d = speed_q + 4'd1;
          thr_d   = thr_q + STEP_V;
        end
      end
      S_LOST: begin
        banked_d = bank_sum[14] ? 14'h3fff : bank_sum[13:0];
        lives_d  = lives_q - 2'd1;
        state_d  = (lives_q == 2'd1) ? S_OVER : S_SERVE;
      end
      S_OVER, S_WIN: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they align with o_state.
  always_comb begin
    mode_d = 1'b0;
    anim_d = 1'b0;
    unique case (state_d)
      S_SERVE, S_OVER, S_WIN: mode_d = 1'b1;
      S_PLAY: begin
        mode_d = 1'b1;
        anim_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign total_d = tot_sum[14] ? 14'h3fff : tot_sum[13:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      anim_q   <= 1'b0;
      speed_q  <= 4'd1;
      lives_q  <= LIVES_V;
      total_q  <= 14'd0;
      banked_q <= 14'd0;
      cnt_q    <= 8'd0;
      thr_q    <= STEP_V;
      start_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      anim_q   <= anim_d;
      speed_q  <= speed_d;
      lives_q  <= lives_d;
      total_q  <= total_d;
      banked_q <= banked_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      start_q  <= i_start;
    end
  end

  assign o_mode    = mode_q;
  assign o_animate = anim_q;
  assign o_speed   = speed_q;
  assign o_lives   = lives_q;
  assign o_total   = total_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed test of game_ctrl with default parameters.
// Drives serve/play/loss/win/reset sequences and checks hand-computed values.
module tb_game_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ani_stb;
  logic        i_start;
  logic        i_endgame;
  logic        i_win;
  logic [13:0] i_score;
  logic        o_mode;
  logic        o_animate;
  logic [3:0]  o_speed;
  logic [1:0]  o_lives;
  logic [13:0] o_total;
  logic [2:0]  o_state;

  int n_tot = 0;
  int n_bad = 0;

  game_ctrl dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ani_stb (i_ani_stb),
    .i_start   (i_start),
    .i_endgame (i_endgame),
    .i_win     (i_win),
    .i_score   (i_score),
    .o_mode    (o_mode),
    .o_animate (o_animate),
    .o_speed   (o_speed),
    .o_lives   (o_lives),
    .o_total   (o_total),
    .o_state   (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe();
    i_ani_stb = 1'b1;
    tick();
    i_ani_stb = 1'b0;
  endtask

  task automatic press();
    i_start = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic serve_to_play(input string tag);
    for (int i = 0; i < 59; i++) strobe();
    chk({tag, ".serve59"}, o_state, 1);
    strobe();
    chk({tag, ".play"}, o_state, 2);
    chk({tag, ".anim"}, o_animate, 1);
  endtask

  task automatic lose();
    i_endgame = 1'b1;
    tick();
    i_endgame = 1'b0;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_ani_stb = 1'b0;
    i_start   = 1'b1;
    i_endgame = 1'b0;
    i_win     = 1'b0;
    i_score   = 14'd0;
    #12;
    chk("rst.state", o_state, 0);
    chk("rst.mode", o_mode, 0);
    chk("rst.speed", o_speed, 1);
    chk("rst.lives", o_lives, 3);
    chk("rst.total", o_total, 0);
    i_rst_n = 1'b1;
    repeat (3) tick();
    chk("held.idle", o_state, 0);

    // game 1: three losses
    press();
    chk("g1.serve", o_state, 1);
    chk("g1.lives", o_lives, 3);
    chk("g1.speed", o_speed, 1);
    chk("g1.mode", o_mode, 1);
    chk("g1.anim0", o_animate, 0);
    serve_to_play("g1a");

    i_score = 14'd35;
    tick();
    chk("g1.tot35", o_total, 35);
    lose();
    chk("g1.lost", o_state, 3);
    chk("g1.lostmode", o_mode, 0);
    tick();
    chk("g1.reserve", o_state, 1);
    chk("g1.lives2", o_lives, 2);
    i_score = 14'd0;
    tick();
    chk("g1.bank35", o_total, 35);

    serve_to_play("g1b");
    i_score = 14'd10;
    tick();
    strobe();
    chk("spd.45", o_speed, 1);
    i_score = 14'd20;
    tick();
    chk("spd.tot55", o_total, 55);
    strobe();
    chk("spd.55", o_speed, 2);
    strobe();
    chk("spd.55b", o_speed, 2);
    i_score = 14'd70;
    tick();
    strobe();
    chk("spd.105", o_speed, 3);
    i_score = 14'd200;
    tick();
    strobe();
    chk("spd.235a", o_speed, 4);
    strobe();
    chk("spd.max", o_speed, 4);

    lose();
    tick();
    chk("g1.lives1", o_lives, 1);
    chk("g1.spdkeep", o_speed, 4);
    i_score = 14'd0;
    tick();
    chk("g1.bank235", o_total, 235);

    serve_to_play("g1c");
    i_score = 14'h3fff;
    tick();
    chk("g1.sat", o_total, 16383);
    lose();
    tick();
    chk("g1.over", o_state, 4);
    chk("g1.lives0", o_lives, 0);
    chk("g1.overmode", o_mode, 1);
    chk("g1.overanim", o_animate, 0);
    i_score = 14'd0;
    strobe();
    chk("g1.overstb", o_state, 4);
    chk("g1.banksat", o_total, 16383);
    press();
    chk("g1.idle", o_state, 0);
    chk("g1.idlemode", o_mode, 0);

    // game 2: win beats endgame
    press();
    chk("g2.serve", o_state, 1);
    tick();
    chk("g2.tot0", o_total, 0);
    serve_to_play("g2");
    i_score = 14'd30;
    tick();
    i_win     = 1'b1;
    i_endgame = 1'b1;
    tick();
    chk("g2.win", o_state, 5);
    chk("g2.lives", o_lives, 3);
    tick();
    chk("g2.total", o_total, 30);
    i_win     = 1'b0;
    i_endgame = 1'b0;
    i_score   = 14'd0;
    press();
    chk("g2.idle", o_state, 0);

    // game 3: async reset mid-play
    press();
    serve_to_play("g3");
    i_score = 14'd120;
    tick();
    strobe();
    strobe();
    chk("g3.spd3", o_speed, 3);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("ar.state", o_state, 0);
    chk("ar.speed", o_speed, 1);
    chk("ar.total", o_total, 0);
    chk("ar.mode", o_mode, 0);
    chk("ar.anim", o_animate, 0);
    chk("ar.lives", o_lives, 3);
    i_score = 14'd0;
    #3;
    i_rst_n = 1'b1;
    repeat (2) tick();
    chk("ar.stay", o_state, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
